// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-read SRAM among NREQ requesters; grants are registered, beats go straight to the SRAM.
// Read data returns one cycle after its beat; an owner stalls by dropping req, and it is forced off after MAX_BURST beats when others wait.
module sram_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int AW        = 11,
    parameter int DW        = 20,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_din,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n;
    logic [CW-1:0]   beat_cnt, beat_cnt_n;
    logic [NREQ-1:0] gnt_n, rvalid_n;
    logic            busy_n;

    logic            beat, last_beat, others, release_own;
    logic [IW-1:0]   owner_inc, sel_start, win;
    logic            win_vld;

    assign beat      = (state == OWN) && req[owner];
    assign last_beat = beat && (beat_cnt == CW'(MAX_BURST - 1));
    assign others    = |(req & ~gnt);
    assign owner_inc = IW'((int'(owner) + 1) % NREQ);
    assign sel_start = (state == OWN) ? owner_inc : rr_ptr;

    // Rotating-priority scan; during a release it starts just past the owner,
    // so the outgoing owner is considered last.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(sel_start) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = IW'(idx);
            end
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        beat_cnt_n  = beat_cnt;
        release_own = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_n    = OWN;
                    owner_n    = win;
                    beat_cnt_n = '0;
                end
            end
            OWN: begin
                release_own = !req[owner] || (last_beat && others);
                if (last_beat) begin
                    beat_cnt_n = '0;
                end else if (beat && beat_cnt != CW'(MAX_BURST)) begin
                    beat_cnt_n = beat_cnt + 1'b1;
                end
                if (release_own) begin
                    rr_ptr_n   = owner_inc;
                    beat_cnt_n = '0;
                    if (win_vld) begin
                        owner_n = win;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n    = (state_n == OWN) ? (NREQ'(1) << owner_n) : '0;
        busy_n   = (state_n == OWN);
        rvalid_n = (beat && !req_we[owner]) ? gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            rvalid   <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            rvalid   <= rvalid_n;
        end
    end

    assign mem_we   = beat && req_we[owner];
    assign mem_addr = beat ? req_addr[int'(owner)*AW +: AW] : '0;
    assign mem_din  = beat ? req_din[int'(owner)*DW +: DW] : '0;
    assign rdata    = mem_dout;

endmodule
